// File: rtl/spi_byte_master.sv
// spi_byte_master: single-byte full-duplex SPI master, MSB first, modes 0..3
module spi_byte_master #(
    parameter int SPI_MODE          = 3,
    parameter int CLKS_PER_HALF_BIT = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);
    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int HW = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [HW-1:0] LEAD = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [HW-1:0] TRAIL = HW'(2 * CLKS_PER_HALF_BIT - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t state, next_state;
    logic [HW-1:0] half_cnt;
    logic [4:0] edge_cnt;
    logic [7:0] tx_byte;
    logic [6:0] rx_shift;
    logic [2:0] tx_idx, rx_idx;
    logic accept, lead, trail, sample, drive;

    assign accept = (state == IDLE) && i_TX_DV && o_TX_Ready;
    assign lead = (state == XFER) && (edge_cnt != 5'd0) && (half_cnt == LEAD);
    assign trail = (state == XFER) && (edge_cnt != 5'd0) && (half_cnt == TRAIL);
    assign sample = CPHA ? trail : lead;
    // the last trailing edge in CPHA=0 would re-drive bit 7; suppress it so MOSI holds bit 0
    assign drive = CPHA ? lead : (trail && edge_cnt != 5'd1);

    // state register; ready tracks the state being entered so it rises one edge after reset release
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= IDLE;
            o_TX_Ready <= 1'b0;
        end else begin
            state <= next_state;
            o_TX_Ready <= (next_state == IDLE);
        end
    end

    // accept a byte from idle; leave the transfer once all 16 clock edges are spent
    always_comb begin
        next_state = state;
        next_state = accept ? XFER : ((state == XFER) && (edge_cnt == 5'd0)) ? IDLE : state;
    end

    // SPI clock, edge counting, MOSI shifting and MISO capture
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            half_cnt <= '0;
            edge_cnt <= 5'd0;
            tx_byte <= 8'h00;
            rx_shift <= 7'h00;
            tx_idx <= 3'd0;
            rx_idx <= 3'd0;
            o_RX_DV <= 1'b0;
            o_RX_Byte <= 8'h00;
            o_SPI_Clk <= CPOL;
            o_SPI_MOSI <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            half_cnt <= ((state == XFER) && (half_cnt != TRAIL)) ? half_cnt + 1'b1 : '0;
            if (accept) begin
                tx_byte <= i_TX_Byte;
                edge_cnt <= 5'd16;
                tx_idx <= CPHA ? 3'd7 : 3'd6;
                rx_idx <= 3'd7;
                if (!CPHA)
                    o_SPI_MOSI <= i_TX_Byte[7];
            end
            if (lead || trail) begin
                o_SPI_Clk <= ~o_SPI_Clk;
                edge_cnt <= edge_cnt - 5'd1;
            end
            if (drive) begin
                o_SPI_MOSI <= tx_byte[tx_idx];
                tx_idx <= tx_idx - 3'd1;
            end
            if (sample) begin
                rx_shift <= {rx_shift[5:0], i_SPI_MISO};
                rx_idx <= rx_idx - 3'd1;
                if (rx_idx == 3'd0) begin
                    o_RX_Byte <= {rx_shift, i_SPI_MISO};
                    o_RX_DV <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: directed checks of the SPI byte master in all four modes
module tb_spi_byte_master;
    localparam logic [3:0] CPOL_V = 4'b1100;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [3:0] tx_dv = 4'h0;
    logic [3:0] ready, rx_dv, spi_clk, mosi, miso;
    logic [7:0] rx_byte [4];
    logic slave_en = 1'b0;
    logic slave_load = 1'b0;
    logic [7:0] slave_sh, slave_rx;
    logic [3:0] clk_q;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int toggles [4];
    int dv_cnt [4];
    int bad_half [4];
    int last_t [4];

    always #5 i_Clk = ~i_Clk;

    for (genvar g = 0; g < 4; g++) begin : dut_g
        assign miso[g] = (g == 0 && slave_en) ? slave_sh[7] : mosi[g];
        spi_byte_master #(.SPI_MODE(g), .CLKS_PER_HALF_BIT(4)) dut (
            .i_Clk(i_Clk),
            .i_Rst(i_Rst),
            .i_TX_Byte(tx_byte),
            .i_TX_DV(tx_dv[g]),
            .o_TX_Ready(ready[g]),
            .o_RX_DV(rx_dv[g]),
            .o_RX_Byte(rx_byte[g]),
            .o_SPI_Clk(spi_clk[g]),
            .i_SPI_MISO(miso[g]),
            .o_SPI_MOSI(mosi[g])
        );
    end

    // mode-0 slave: shifts its byte out on falling SPI edges, captures MOSI on rising edges
    always @(negedge spi_clk[0] or posedge slave_load) begin
        if (slave_load) slave_sh <= 8'h3C;
        else slave_sh <= {slave_sh[6:0], 1'b0};
    end

    always @(posedge spi_clk[0]) slave_rx <= {slave_rx[6:0], mosi[0]};

    // count RX strobes and SPI clock toggles, flag any in-transfer half-period other than 4 cycles
    always @(posedge i_Clk) begin
        cyc <= cyc + 1;
        for (int m = 0; m < 4; m++) begin
            clk_q[m] <= spi_clk[m];
            if (rx_dv[m] === 1'b1) dv_cnt[m] <= dv_cnt[m] + 1;
            if (i_Rst || ready[m] === 1'b1) last_t[m] <= -1;
            else if (spi_clk[m] !== clk_q[m]) begin
                toggles[m] <= toggles[m] + 1;
                if (last_t[m] != -1 && cyc - last_t[m] != 4) bad_half[m] <= bad_half[m] + 1;
                last_t[m] <= cyc;
            end
        end
    end

    task automatic wait_ready(input int m);
        int n;
        n = 0;
        while (ready[m] !== 1'b1 && n < 500) begin
            @(negedge i_Clk);
            n++;
        end
        checks++;
        if (ready[m] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout mode %0d: ready=%b required 1", m, ready[m]);
        end
    endtask

    task automatic send(input int m, input logic [7:0] b);
        wait_ready(m);
        tx_byte = b;
        tx_dv[m] = 1'b1;
        @(negedge i_Clk);
        tx_dv[m] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (10) @(negedge i_Clk);
        checks++;
        if (spi_clk !== CPOL_V) begin errors++; $display("FAIL reset_spi_clk: got %b required %b", spi_clk, CPOL_V); end
        checks++;
        if (mosi !== 4'h0) begin errors++; $display("FAIL reset_mosi: got %b required 0000", mosi); end
        checks++;
        if (rx_dv !== 4'h0) begin errors++; $display("FAIL reset_rx_dv: got %b required 0000", rx_dv); end
        checks++;
        if (ready !== 4'h0) begin errors++; $display("FAIL reset_ready_low: got %b required 0000", ready); end
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (rx_byte[m] !== 8'h00) begin errors++; $display("FAIL reset_rx_byte mode %0d: got %h required 00", m, rx_byte[m]); end
        end
        i_Rst = 1'b0;
        @(negedge i_Clk);
        checks++;
        if (ready !== 4'hF) begin errors++; $display("FAIL reset_ready_rise: got %b required 1111", ready); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [3];
        int d0, t0;
        seq = '{8'hC1, 8'hBE, 8'hEF};
        t0 = toggles[3];
        for (int i = 0; i < 3; i++) begin
            d0 = dv_cnt[3];
            send(3, seq[i]);
            wait_ready(3);
            checks++;
            if (rx_byte[3] !== seq[i]) begin errors++; $display("FAIL b2b_rx byte %0d: got %h required %h", i, rx_byte[3], seq[i]); end
            checks++;
            if (dv_cnt[3] - d0 !== 1) begin errors++; $display("FAIL b2b_rx_dv byte %0d: got %0d pulses required 1", i, dv_cnt[3] - d0); end
        end
        checks++;
        if (toggles[3] - t0 !== 48) begin errors++; $display("FAIL b2b_toggles: got %0d required 48", toggles[3] - t0); end
        checks++;
        if (bad_half[3] !== 0) begin errors++; $display("FAIL b2b_half_period: got %0d bad required 0", bad_half[3]); end
    endtask

    task automatic test_modes;
        int d0, t0;
        for (int m = 0; m < 3; m++) begin
            d0 = dv_cnt[m];
            t0 = toggles[m];
            send(m, 8'hA5);
            wait_ready(m);
            checks++;
            if (rx_byte[m] !== 8'hA5) begin errors++; $display("FAIL mode_rx mode %0d: got %h required a5", m, rx_byte[m]); end
            checks++;
            if (dv_cnt[m] - d0 !== 1) begin errors++; $display("FAIL mode_rx_dv mode %0d: got %0d required 1", m, dv_cnt[m] - d0); end
            checks++;
            if (toggles[m] - t0 !== 16) begin errors++; $display("FAIL mode_toggles mode %0d: got %0d required 16", m, toggles[m] - t0); end
            checks++;
            if (bad_half[m] !== 0) begin errors++; $display("FAIL mode_half_period mode %0d: got %0d bad required 0", m, bad_half[m]); end
            checks++;
            if (spi_clk[m] !== CPOL_V[m]) begin errors++; $display("FAIL mode_idle_clk mode %0d: got %b required %b", m, spi_clk[m], CPOL_V[m]); end
        end
    endtask

    task automatic test_slave;
        slave_en = 1'b1;
        slave_load = 1'b1;
        #1 slave_load = 1'b0;
        @(negedge i_Clk);
        send(0, 8'h00);
        wait_ready(0);
        checks++;
        if (rx_byte[0] !== 8'h3C) begin errors++; $display("FAIL slave_rx: got %h required 3c", rx_byte[0]); end
        checks++;
        if (slave_rx !== 8'h00) begin errors++; $display("FAIL slave_mosi: got %h required 00", slave_rx); end
        slave_en = 1'b0;
    endtask

    task automatic test_ignore_dv;
        int d0, t0;
        d0 = dv_cnt[3];
        t0 = toggles[3];
        send(3, 8'h81);
        repeat (20) @(negedge i_Clk);
        tx_byte = 8'hFF;
        tx_dv[3] = 1'b1;
        @(negedge i_Clk);
        tx_dv[3] = 1'b0;
        wait_ready(3);
        checks++;
        if (rx_byte[3] !== 8'h81) begin errors++; $display("FAIL ignore_rx: got %h required 81", rx_byte[3]); end
        repeat (40) @(negedge i_Clk);
        checks++;
        if (ready[3] !== 1'b1) begin errors++; $display("FAIL ignore_idle: ready=%b required 1", ready[3]); end
        checks++;
        if (dv_cnt[3] - d0 !== 1) begin errors++; $display("FAIL ignore_rx_dv: got %0d required 1", dv_cnt[3] - d0); end
        checks++;
        if (toggles[3] - t0 !== 16) begin errors++; $display("FAIL ignore_toggles: got %0d required 16", toggles[3] - t0); end
    endtask

    task automatic test_abort;
        int d0, t0, n;
        d0 = dv_cnt[3];
        t0 = toggles[3];
        send(3, 8'h5A);
        n = 0;
        while (toggles[3] - t0 < 6 && n < 500) begin
            @(negedge i_Clk);
            n++;
        end
        checks++;
        if (toggles[3] - t0 !== 6) begin errors++; $display("FAIL abort_wait: got %0d toggles required 6", toggles[3] - t0); end
        i_Rst = 1'b1;
        #1;
        checks++;
        if (spi_clk[3] !== 1'b1) begin errors++; $display("FAIL abort_spi_clk: got %b required 1", spi_clk[3]); end
        checks++;
        if (mosi[3] !== 1'b0 || ready[3] !== 1'b0 || rx_dv[3] !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: mosi=%b ready=%b rx_dv=%b required 0 0 0", mosi[3], ready[3], rx_dv[3]);
        end
        checks++;
        if (rx_byte[3] !== 8'h00) begin errors++; $display("FAIL abort_rx_byte: got %h required 00", rx_byte[3]); end
        repeat (3) @(negedge i_Clk);
        i_Rst = 1'b0;
        repeat (40) @(negedge i_Clk);
        checks++;
        if (dv_cnt[3] !== d0) begin errors++; $display("FAIL abort_no_rx_dv: got %0d pulses required 0", dv_cnt[3] - d0); end
        send(3, 8'h5A);
        wait_ready(3);
        checks++;
        if (rx_byte[3] !== 8'h5A) begin errors++; $display("FAIL abort_retry_rx: got %h required 5a", rx_byte[3]); end
        checks++;
        if (dv_cnt[3] - d0 !== 1) begin errors++; $display("FAIL abort_retry_rx_dv: got %0d required 1", dv_cnt[3] - d0); end
    endtask

    initial begin
        #1 i_Rst = 1'b1;
        @(negedge i_Clk);
        test_reset;
        test_back_to_back;
        test_modes;
        test_slave;
        test_ignore_dv;
        test_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
